// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control stages.
//   OP_LDR / OP_STR  : memory opcodes in ir[OP_HI:OP_LO]
//   mem_state_t      : memory-phase FSM states
//   writes_reg()     : does an instruction write the register file
//   is_mem_op()      : is an instruction LDR or STR
package ctrl_pkg;

  localparam int unsigned OP_HI = 15;
  localparam int unsigned OP_LO = 11;

  localparam logic [4:0] OP_LDR = 5'b01101;
  localparam logic [4:0] OP_STR = 5'b01100;

  // Width of the memory wait counter; covers TIMEOUT_CYCLES up to 255.
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Zero word is a NOP; stores and the branch class (ir[15:14]==11) do not write back.
  function automatic logic writes_reg(input logic [15:0] ir);
    return (ir != '0) && (ir[OP_HI:OP_LO] != OP_STR) && (ir[15:14] != 2'b11);
  endfunction

  function automatic logic is_mem_op(input logic [15:0] ir);
    return (ir[OP_HI:OP_LO] == OP_LDR) || (ir[OP_HI:OP_LO] == OP_STR);
  endfunction

endpackage

// File: rtl/ctrl_mem_if.sv
// Data memory request/acknowledge bus.
//   master (ctrl_mem side): drives o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata,
//                           receives i_mem_rdata/i_mem_ack
//   slave  (memory side)  : the mirror image
interface ctrl_mem_if #(
  parameter int unsigned DW = 16
) ();

  logic          o_mem_req;
  logic          o_mem_we;
  logic [DW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ack;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata, i_mem_ack
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata, i_mem_ack
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Wait counter for an outstanding memory request.
//   clk, rst : clock, synchronous active-low reset
//   clr      : force count to 0 (wins over en)
//   en       : increment
//   tc       : count has reached TIMEOUT_CYCLES-1
module mem_timeout_cnt
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ctrl_mem.sv
// Memory-phase pipeline control.
//   clk, rst      : clock, synchronous active-low reset
//   i_ir_mem      : instruction in the memory phase
//   i_alu_result  : address for LDR/STR, write-back data otherwise
//   i_store_data  : store value for STR
//   mem           : data memory bus (ctrl_mem_if.master)
//   o_stall_r     : registered stall to upstream stages
//   o_mem_err     : one-cycle pulse when a request is abandoned
//   o_ir_wb, o_wb_data, o_wb_en, o_wb_reg : write-back phase controls
module ctrl_mem
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned DW             = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_ir_mem,
  input  logic [DW-1:0] i_alu_result,
  input  logic [DW-1:0] i_store_data,
  ctrl_mem_if.master    mem,
  output logic          o_stall_r,
  output logic          o_mem_err,
  output logic [DW-1:0] o_ir_wb,
  output logic [DW-1:0] o_wb_data,
  output logic          o_wb_en,
  output logic [2:0]    o_wb_reg
);

  mem_state_t    state_q, state_d;
  logic [DW-1:0] ir_lat_q, ir_lat_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          req_q, req_d;
  logic          stall_q, stall_d;
  logic          err_q, err_d;
  logic [DW-1:0] ir_wb_q, ir_wb_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          wb_en_q, wb_en_d;

  logic cnt_clr, cnt_en, cnt_tc;

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    ir_lat_d  = ir_lat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    req_d     = req_q;
    stall_d   = stall_q;
    err_d     = 1'b0;
    ir_wb_d   = ir_wb_q;
    wb_data_d = wb_data_q;
    wb_en_d   = wb_en_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Holding the counter clear in IDLE guarantees it starts at 0 on entry to BUSY.
        cnt_clr = 1'b1;
        if (is_mem_op(i_ir_mem)) begin
          ir_lat_d  = i_ir_mem;
          addr_d    = i_alu_result;
          wdata_d   = i_store_data;
          we_d      = (i_ir_mem[OP_HI:OP_LO] == OP_STR);
          req_d     = 1'b1;
          stall_d   = 1'b1;
          ir_wb_d   = '0;
          wb_data_d = '0;
          wb_en_d   = 1'b0;
          state_d   = BUSY;
        end else begin
          ir_wb_d   = i_ir_mem;
          wb_data_d = i_alu_result;
          wb_en_d   = writes_reg(i_ir_mem);
        end
      end

      BUSY: begin
        cnt_en = 1'b1;
        // Ack is tested first so an ack coinciding with terminal count completes normally.
        if (mem.i_mem_ack) begin
          req_d   = 1'b0;
          stall_d = 1'b0;
          ir_wb_d = ir_lat_q;
          if (ir_lat_q[OP_HI:OP_LO] == OP_LDR) begin
            wb_data_d = mem.i_mem_rdata;
            wb_en_d   = 1'b1;
          end else begin
            wb_data_d = '0;
            wb_en_d   = 1'b0;
          end
          state_d = IDLE;
        end else if (cnt_tc) begin
          req_d     = 1'b0;
          stall_d   = 1'b0;
          err_d     = 1'b1;
          ir_wb_d   = '0;
          wb_data_d = '0;
          wb_en_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          ir_wb_d   = '0;
          wb_data_d = '0;
          wb_en_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ir_lat_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      stall_q   <= 1'b0;
      err_q     <= 1'b0;
      ir_wb_q   <= '0;
      wb_data_q <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_lat_q  <= ir_lat_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      req_q     <= req_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
      ir_wb_q   <= ir_wb_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
    end
  end

  assign mem.o_mem_req   = req_q;
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;

  assign o_stall_r = stall_q;
  assign o_mem_err = err_q;
  assign o_ir_wb   = ir_wb_q;
  assign o_wb_data = wb_data_q;
  assign o_wb_en   = wb_en_q;
  assign o_wb_reg  = ir_wb_q[10:8];

endmodule
